painterengine_gpu_alphablend_stream: RTL and testbench

- Pipelined N-layer ARGB compositor for the GPU raster back end.
- Blends LAYER_COUNT source pixels bottom-to-top onto a background pixel, one pixel per clock at full throughput.
- Generalises the fixed 2-layer, 8-bit blender: parametric channel width and layer count, selectable blend mode, valid/ready backpressure, output pixel counter.
- Sits between the fragment fetch stage and the framebuffer write stage.

---
 rtl/painterengine_gpu_pkg.sv | 17 +
 rtl/painterengine_gpu_blend_stage.sv | 69 ++++++
 rtl/painterengine_gpu_alphablend_stream.sv | 90 +++++++++
 tb/tb_painterengine_gpu_alphablend_stream.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_pkg.sv
// Shared blend-mode encoding and ARGB channel positions for the alpha-blend stream.
package painterengine_gpu_pkg;

    typedef enum logic [1:0] {
        BLEND_OVER = 2'd0,
        BLEND_ADD  = 2'd1,
        BLEND_MUL  = 2'd2,
        BLEND_PASS = 2'd3
    } blend_mode_e;

    // Channel index within a pixel; the bit offset is index * channel width.
    localparam int CH_B = 0;
    localparam int CH_G = 1;
    localparam int CH_R = 2;
    localparam int CH_A = 3;

endpackage

// File: rtl/painterengine_gpu_blend_stage.sv
// One registered compositing stage: blends a source layer onto the running pixel.
module painterengine_gpu_blend_stage
    import painterengine_gpu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          valid,
    input  blend_mode_e   mode,
    input  logic [4*W-1:0] dst,
    input  logic [4*W-1:0] src,
    output logic          q_valid,
    output logic [4*W-1:0] q_pix
);
    localparam logic [W-1:0] MAX = '1;

    function automatic logic [2*W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // round(x / MAX) without a divider; exact for x <= MAX*MAX
    function automatic logic [W-1:0] div_max(input logic [2*W:0] x);
        logic [2*W:0] t;
        t = x + (2*W+1)'(1 << (W - 1));
        return W'((t + (t >> W)) >> W);
    endfunction

    logic [W-1:0]   as, ad, inv, cs, cd;
    logic [W:0]     sum;
    logic [4*W-1:0] res;

    always_comb begin
        as  = src[CH_A*W +: W];
        ad  = dst[CH_A*W +: W];
        inv = MAX - as;
        cs  = '0;
        cd  = '0;
        sum = '0;
        res = dst;
        if (mode != BLEND_PASS) begin
            res[CH_A*W +: W] = as + div_max({1'b0, mul(ad, inv)});
            for (int c = CH_B; c <= CH_R; c++) begin
                cs = src[c*W +: W];
                cd = dst[c*W +: W];
                case (mode)
                    BLEND_ADD: begin
                        sum = {1'b0, cd} + {1'b0, div_max({1'b0, mul(cs, as)})};
                        res[c*W +: W] = sum[W] ? MAX : sum[W-1:0];
                    end
                    BLEND_MUL: res[c*W +: W] = div_max({1'b0, mul(cd, cs)});
                    default:   res[c*W +: W] = div_max({1'b0, mul(cs, as)} + {1'b0, mul(cd, inv)});
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_pix   <= '0;
        end else if (en) begin
            q_valid <= valid;
            q_pix   <= res;
        end
    end

endmodule

// File: rtl/painterengine_gpu_alphablend_stream.sv
// N-layer ARGB compositor: input register, one blend stage per layer, output pixel counter.
module painterengine_gpu_alphablend_stream
    import painterengine_gpu_pkg::*;
#(
    parameter int CHANNEL_WIDTH = 8,
    parameter int LAYER_COUNT   = 2,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                                   i_wire_clock,
    input  logic                                   i_wire_resetn,
    input  logic                                   i_wire_valid,
    output logic                                   o_wire_ready,
    input  logic [LAYER_COUNT*4*CHANNEL_WIDTH-1:0] i_wire_layers,
    input  logic [4*CHANNEL_WIDTH-1:0]             i_wire_background,
    input  logic [1:0]                             i_wire_mode,
    output logic                                   o_wire_valid,
    input  logic                                   i_wire_ready,
    output logic [4*CHANNEL_WIDTH-1:0]             o_wire_argb,
    input  logic                                   i_wire_count_clear,
    output logic [COUNT_WIDTH-1:0]                 o_wire_pixel_count
);
    localparam int W  = CHANNEL_WIDTH;
    localparam int PW = 4 * W;

    logic                         en;
    logic                         in_valid;
    logic [PW-1:0]                in_bg;
    logic [LAYER_COUNT-1:0][1:0]  mode_pipe;
    logic [LAYER_COUNT:0]         vld_pipe;
    logic [LAYER_COUNT:0][PW-1:0] dat_pipe;
    logic [COUNT_WIDTH-1:0]       pixel_count;

    // The whole pipe advances together; a stalled output freezes every stage.
    assign en           = !o_wire_valid || i_wire_ready;
    assign o_wire_ready = en;

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            in_valid  <= 1'b0;
            in_bg     <= '0;
            mode_pipe <= '0;
        end else if (en) begin
            in_valid     <= i_wire_valid;
            in_bg        <= i_wire_background;
            mode_pipe[0] <= i_wire_mode;
            for (int j = 1; j < LAYER_COUNT; j++) mode_pipe[j] <= mode_pipe[j-1];
        end
    end

    assign vld_pipe[0] = in_valid;
    assign dat_pipe[0] = in_bg;

    for (genvar k = 0; k < LAYER_COUNT; k++) begin : g_layer
        // Layer k is consumed by stage k, so it trails the pixel by k extra registers.
        logic [k:0][PW-1:0] src_dly;

        always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
            if (!i_wire_resetn) begin
                src_dly <= '0;
            end else if (en) begin
                src_dly[0] <= i_wire_layers[k*PW +: PW];
                for (int j = 1; j <= k; j++) src_dly[j] <= src_dly[j-1];
            end
        end

        painterengine_gpu_blend_stage #(.W(W)) u_stage (
            .clk     (i_wire_clock),
            .rst_n   (i_wire_resetn),
            .en      (en),
            .valid   (vld_pipe[k]),
            .mode    (blend_mode_e'(mode_pipe[k])),
            .dst     (dat_pipe[k]),
            .src     (src_dly[k]),
            .q_valid (vld_pipe[k+1]),
            .q_pix   (dat_pipe[k+1])
        );
    end

    assign o_wire_valid = vld_pipe[LAYER_COUNT];
    assign o_wire_argb  = dat_pipe[LAYER_COUNT];

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn)                    pixel_count <= '0;
        else if (i_wire_count_clear)           pixel_count <= '0;
        else if (o_wire_valid && i_wire_ready) pixel_count <= pixel_count + COUNT_WIDTH'(1);
    end

    assign o_wire_pixel_count = pixel_count;

endmodule

// File: tb/tb_painterengine_gpu_alphablend_stream.sv
// Bench for the alpha-blend stream: directed literals plus an in-order reference scoreboard.
module tb_painterengine_gpu_alphablend_stream;
    localparam int W = 8, N = 2, CW = 4;

    logic          clk = 0, rst_n = 0;
    logic          i_valid = 0, o_ready, o_valid, i_ready, i_clear = 0;
    logic [63:0]   i_layers = '0;
    logic [31:0]   i_bg = '0, o_argb;
    logic [1:0]    i_mode = '0;
    logic [CW-1:0] o_count;
    bit            rand_ready = 0;

    int errors = 0, checks = 0;
    logic [31:0] exp_q[$];
    int          cnt_m = 0;
    bit          stall_prev = 0;
    logic [31:0] held = '0;

    painterengine_gpu_alphablend_stream #(.CHANNEL_WIDTH(W), .LAYER_COUNT(N), .COUNT_WIDTH(CW)) dut (
        .i_wire_clock       (clk),
        .i_wire_resetn      (rst_n),
        .i_wire_valid       (i_valid),
        .o_wire_ready       (o_ready),
        .i_wire_layers      (i_layers),
        .i_wire_background  (i_bg),
        .i_wire_mode        (i_mode),
        .o_wire_valid       (o_valid),
        .i_wire_ready       (i_ready),
        .o_wire_argb        (o_argb),
        .i_wire_count_clear (i_clear),
        .o_wire_pixel_count (o_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int rnd(input int x);
        return (2 * x + 255) / 510;
    endfunction

    // Straight arithmetic from the blend rules, 8-bit channels, layer 0 first.
    function automatic logic [31:0] ref_blend(input logic [63:0] lay, input logic [31:0] bg,
                                              input logic [1:0] md);
        int d[4], s[4], as;
        logic [31:0] r;
        for (int c = 0; c < 4; c++) d[c] = int'(bg[c*8 +: 8]);
        if (md != 2'd3) begin
            for (int k = 0; k < N; k++) begin
                for (int c = 0; c < 4; c++) s[c] = int'(lay[k*32 + c*8 +: 8]);
                as = s[3];
                for (int c = 0; c < 3; c++) begin
                    case (md)
                        2'd0: d[c] = rnd(s[c] * as + d[c] * (255 - as));
                        2'd1: d[c] = (d[c] + rnd(s[c] * as) > 255) ? 255 : d[c] + rnd(s[c] * as);
                        default: d[c] = rnd(d[c] * s[c]);
                    endcase
                end
                d[3] = as + rnd(d[3] * (255 - as));
            end
        end
        for (int c = 0; c < 4; c++) r[c*8 +: 8] = 8'(d[c]);
        return r;
    endfunction

    function automatic logic [31:0] px(input int a, input int r, input int g, input int b);
        return {8'(a), 8'(r), 8'(g), 8'(b)};
    endfunction

    // Scoreboard, count model and stall-stability check, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            cnt_m = 0;
            stall_prev = 0;
            check("reset_valid", 64'(o_valid), 64'd0);
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(o_valid), 64'd1);
                check("hold_argb", 64'(o_argb), 64'(held));
            end
            check("pixel_count", 64'(o_count), 64'(cnt_m));
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got %0h expected none", o_argb);
                end else begin
                    check("stream_pix", 64'(o_argb), 64'(exp_q.pop_front()));
                end
            end
            if (i_valid && o_ready) exp_q.push_back(ref_blend(i_layers, i_bg, i_mode));
            if (i_clear) cnt_m = 0;
            else if (o_valid && i_ready) cnt_m = (cnt_m + 1) % 16;
            stall_prev = o_valid && !i_ready;
            held = o_argb;
        end
    end

    task automatic send(input logic [63:0] lay, input logic [31:0] bg, input logic [1:0] md);
        int n = 0;
        logic hs = 0;
        i_layers = lay; i_bg = bg; i_mode = md; i_valid = 1;
        do begin
            @(negedge clk); hs = o_ready;
            @(posedge clk); #1; n++;
        end while (!hs && n < 60);
        if (!hs) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no handshake expected one within 60 cycles");
        end
        i_valid = 0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] exp);
        int n = 0;
        while (!o_valid && n < 20) begin @(posedge clk); #1; n++; end
        check(name, 64'(o_argb), 64'(exp));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] lay;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_argb", 64'(o_argb), 64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        rst_n = 1;
        @(posedge clk); #1;

        // Model pinned against hand-computed literals
        check("model_over", 64'(ref_blend({px(128,87,68,55), px(128,192,128,28)}, px(64,64,64,64), 2'd0)),
              64'(px(208,107,82,51)));
        check("model_add", 64'(ref_blend({px(255,100,100,100), px(255,100,100,100)}, px(64,250,250,250), 2'd1)),
              64'(px(255,255,255,255)));

        // Normal-over with exact latency
        send({px(128,87,68,55), px(128,192,128,28)}, px(64,64,64,64), 2'd0);
        check("lat_cyc1", 64'(o_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_cyc2", 64'(o_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_cyc3", 64'(o_valid), 64'd1);
        check("over_argb", 64'(o_argb), 64'(px(208,107,82,51)));
        @(posedge clk); #1;

        // Alpha boundaries, saturation, multiply, pass
        send({px(255,10,20,30), px(0,50,60,70)}, px(64,64,64,64), 2'd0);
        expect_out("alpha_0_255", px(255,10,20,30));
        send({px(0,200,100,50), px(0,1,2,3)}, px(77,11,22,33), 2'd0);
        expect_out("alpha_all0", px(77,11,22,33));
        send({px(255,100,100,100), px(255,100,100,100)}, px(64,250,250,250), 2'd1);
        expect_out("add_sat", px(255,255,255,255));
        send({px(0,255,255,255), px(255,128,255,0)}, px(255,200,100,255), 2'd2);
        expect_out("mul", px(255,100,100,0));
        send({px(255,1,2,3), px(255,4,5,6)}, px(9,8,7,6), 2'd3);
        expect_out("pass", px(9,8,7,6));

        // Stream with random backpressure and per-pixel modes
        rand_ready = 1;
        for (int i = 0; i < 20; i++) begin
            lay = {$urandom, $urandom};
            if (i % 5 == 0) lay[31:24] = 8'd0;
            if (i % 7 == 0) lay[63:56] = 8'd255;
            send(lay, $urandom, 2'($urandom_range(0, 3)));
        end
        rand_ready = 0;
        drain();

        // Clear
        i_clear = 1; @(posedge clk); #1; i_clear = 0;
        check("clear_count", 64'(o_count), 64'd0);

        // Reset with three pixels in flight
        for (int i = 0; i < 3; i++) send({$urandom, $urandom}, $urandom, 2'd0);
        rst_n = 0; #1;
        check("midrst_valid", 64'(o_valid), 64'd0);
        check("midrst_count", 64'(o_count), 64'd0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1;
        repeat (6) begin
            @(posedge clk); #1;
            check("no_stale", 64'(o_valid), 64'd0);
        end
        check("post_rst_count", 64'(o_count), 64'd0);

        // Counter wrap and clear-beats-increment
        for (int i = 0; i < 17; i++) send({$urandom, $urandom}, $urandom, 2'd1);
        drain();
        check("count_wrap", 64'(o_count), 64'd1);
        send({px(255,1,1,1), px(0,0,0,0)}, px(1,2,3,4), 2'd0);
        begin
            int n = 0;
            while (!o_valid && n < 20) begin @(posedge clk); #1; n++; end
        end
        check("clr_hs_valid", 64'(o_valid), 64'd1);
        i_clear = 1; @(posedge clk); #1; i_clear = 0;
        check("clr_priority", 64'(o_count), 64'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
